// File: rtl/cpu_debug_display_if.sv
// Board-side bundle for the CPU debug display: step button, word/flag inputs from the CPU,
// and the step clock plus 7-segment outputs driven back by the display block.
interface cpu_debug_display_if;
  logic        btn_step;
  logic [1:0]  sel;
  logic [15:0] word1;
  logic [15:0] word2;
  logic [15:0] word3;
  logic [15:0] word4;
  logic        reg_wre;
  logic        step_clk;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output btn_step, sel, word1, word2, word3, word4, reg_wre,
    input  step_clk, an, seg, dp
  );

  modport slave (
    input  btn_step, sel, word1, word2, word3, word4, reg_wre,
    output step_clk, an, seg, dp
  );
endinterface

// File: rtl/cpu_debug_display.sv
// Debounced single-step clock generator and 4-digit multiplexed hex display of a selected
// CPU debug word, with the RegWre flag shown on the rightmost decimal point.
module cpu_debug_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned STEP_LOW = 4
) (
  input logic                CLK,
  input logic                Reset,
  cpu_debug_display_if.slave dbg
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned LowW  = $clog2(STEP_LOW + 1);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [LowW-1:0]  LowLast  = LowW'(STEP_LOW - 1);

  typedef enum logic [0:0] {StIdle, StLow} step_state_e;

  // Button synchronizer and debouncer
  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d, stable_prev_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      // The new level must be seen for DEBOUNCE consecutive cycles before it is accepted.
      if (deb_cnt_q == DebLast) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      sync1_q       <= dbg.btn_step;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // Step pulse FSM
  step_state_e     state_q, state_d;
  logic [LowW-1:0] low_cnt_q, low_cnt_d;
  logic            step_clk_q, step_clk_d;
  logic            press;

  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    step_clk_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (press) begin
          state_d   = StLow;
          low_cnt_d = '0;
        end
      end
      StLow: begin
        // Presses seen while low are dropped, not queued.
        if (low_cnt_q == LowLast) begin
          state_d = StIdle;
        end else begin
          low_cnt_d = low_cnt_q + LowW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    step_clk_d = (state_d == StIdle);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      low_cnt_q  <= '0;
      step_clk_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      step_clk_q <= step_clk_d;
    end
  end

  assign dbg.step_clk = step_clk_q;

  // Digit scan and per-frame snapshot
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             wre_shadow_q, wre_shadow_d;
  logic [15:0]      word_sel;
  logic             tick;

  always_comb begin
    unique case (dbg.sel)
      2'd0: word_sel = dbg.word1;
      2'd1: word_sel = dbg.word2;
      2'd2: word_sel = dbg.word3;
      2'd3: word_sel = dbg.word4;
    endcase
  end

  always_comb begin
    tick         = (scan_cnt_q == ScanLast);
    scan_cnt_d   = tick ? '0 : scan_cnt_q + ScanW'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    wre_shadow_d = wre_shadow_q;
    // Snapshot only at the frame wrap so all four digits come from one word.
    if (tick && (idx_q == 2'd3)) begin
      shadow_d     = word_sel;
      wre_shadow_d = dbg.reg_wre;
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] nibble;

  always_comb begin
    nibble = shadow_q[{idx_q, 2'b00} +: 4];
    an_d   = ~(4'b0001 << idx_q);
    seg_d  = hex_to_seg(nibble);
    dp_d   = ~((idx_q == 2'd0) & wre_shadow_q);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      scan_cnt_q   <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      wre_shadow_q <= 1'b0;
      an_q         <= 4'b1110;
      seg_q        <= 7'b1000000;
      dp_q         <= 1'b1;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      wre_shadow_q <= wre_shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign dbg.an  = an_q;
  assign dbg.seg = seg_q;
  assign dbg.dp  = dp_q;

endmodule

// File: doc/cpu_debug_display.md
CPU_DEBUG_DISPLAY -- requirements
Module: cpu_debug_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles each digit stays lit (minimum 2).
REQ-002 Parameter DEBOUNCE, default 1000000, SHALL set the cycles btn_step must hold a new level before it is accepted (minimum 1).
REQ-003 Parameter STEP_LOW, default 4, SHALL set the step_clk low-pulse width in cycles (minimum 1).
REQ-004 Clock and reset are decided: one clock; reset is asynchronous and active-low, with ports named CLK and Reset.
REQ-005 Port CLK, input, 1 bit: board clock; all state updates on its rising edge.
REQ-006 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port btn_step, input, 1 bit: raw, asynchronous, bouncing step button (high = pressed).
REQ-008 Port sel, input, 2 bits: selects the displayed word (0 = word1, 1 = word2, 2 = word3, 3 = word4).
REQ-009 Ports word1, word2, word3, word4, inputs, 16 bits each: CPU debug words (PC pair, RS, RT, ALU/DB).
REQ-010 Port reg_wre, input, 1 bit: CPU RegWre status flag.
REQ-011 Port step_clk, output, 1 bit: negative-pulse CPU clock; idles high.
REQ-012 Port an, output, 4 bits: digit enables, active-low; an[0] is the rightmost digit.
REQ-013 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-014 Port dp, output, 1 bit: decimal point, active-low.

Function
REQ-015 btn_step SHALL pass through a two-flop synchronizer before any use.
REQ-016 Debounce: while the synchronized level differs from the stable level, a counter SHALL increment each cycle.
REQ-017 Debounce: when that counter reaches DEBOUNCE, the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-018 Debounce: the counter SHALL clear on any cycle where the synchronized level equals the stable level.
REQ-019 Step FSM SHALL have two states: IDLE (step_clk = 1) and LOW (step_clk = 0).
REQ-020 IDLE -> LOW SHALL occur on the cycle after a stable-level 0->1 transition; step_clk is registered.
REQ-021 LOW SHALL last exactly STEP_LOW cycles and then return to IDLE.
REQ-022 Stable 0->1 transitions that occur during LOW SHALL be ignored (no queuing); stable 1->0 transitions SHALL have no effect.
REQ-023 Scan divider: a counter SHALL count 0..SCAN_DIV-1 and wrap, asserting a one-cycle tick at SCAN_DIV-1.
REQ-024 On each tick, digit index idx (2 bits) SHALL advance, wrapping 3->0.
REQ-025 Snapshot: on a tick where idx wraps 3->0, a 16-bit shadow SHALL capture the sel-selected word and a 1-bit shadow SHALL capture reg_wre.
REQ-026 Changes to sel or the word inputs mid-frame SHALL appear only from the next frame; all four digits of one frame come from one snapshot.
REQ-027 Outputs an, seg and dp SHALL be registered and updated from the current idx and shadow values.
REQ-028 an SHALL be ~(4'b0001 << idx); exactly one digit is active at any time.
REQ-029 seg SHALL show shadow nibble idx (idx 0 = bits 3:0) as active-low hex.
REQ-030 Required hex encodings include 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110; all 16 values SHALL have a defined encoding.
REQ-031 dp SHALL be 0 only when idx = 0 and the reg_wre shadow = 1; otherwise dp SHALL be 1.

Reset
REQ-032 Asserting Reset low SHALL immediately clear the synchronizer, stable level, debounce counter, scan counter, idx and both shadows.
REQ-033 Asserting Reset low SHALL immediately force step_clk = 1, an = 1110, seg = 1000000 and dp = 1.
REQ-034 Reset asserted during LOW SHALL abort the pulse: step_clk returns to 1 asynchronously and no pulse resumes after reset is released.
REQ-035 After release, the first stable 0->1 transition SHALL require a full DEBOUNCE hold measured from the release.

Verification (SCAN_DIV=4, DEBOUNCE=3, STEP_LOW=2)
REQ-036 Reset then idle -> step_clk=1, an=1110, seg=1000000, dp=1; an steps 1101, 1011, 0111, 1110 every 4 cycles.
REQ-037 sel=2, word3=16'h8A1F, reg_wre=1 -> after the next frame wrap: digit 0 seg=0001110 with dp=0; then 1111001, 0001000, 0000000 with dp=1.
REQ-038 btn_step held high -> exactly one step_clk low pulse of 2 cycles; holding the button longer produces no further pulses.
REQ-039 btn_step glitches high for 2 cycles -> no pulse and the debounce counter returns to 0.
REQ-040 sel changed 0->3 at idx=1 -> digits 2 and 3 of the current frame still show word1; word4 appears from the next idx=0.
REQ-041 Reset asserted on the first LOW cycle -> step_clk=1 immediately; no pulse occurs after release until a new debounced press.
